// File: rtl/reg_file_param.sv
// ============================================================================
// reg_file_param
// ----------------------------------------------------------------------------
// Parametrised general-purpose register file for the RISC-V datapath.
// Two registered read ports and one write port can be used in the same cycle.
// Register 0 can be hardwired to zero. A hardware sequencer zeroes the array,
// one entry per cycle, after reset release or on an init request.
//
// Parameters
//   XLEN      data width in bits
//   NREG      number of registers (2..256, need not be a power of two)
//   AW        address width, derived from NREG (do not override)
//   ZERO_REG  1: register 0 reads as zero and ignores writes
//
// Ports
//   clk       clock, all logic on the rising edge
//   rst       asynchronous active-low reset
//   init      synchronous clear request (single-cycle pulse)
//   busy      clear sequence in progress, array operations ignored
//   we        write enable
//   rd        write address
//   data_in   write data
//   re        read enable (both ports)
//   rs1, rs2  read addresses
//   rs1_out   registered read data, port 1
//   rs2_out   registered read data, port 2
//   rs_valid  read data valid, one-cycle pulse per accepted read
//
// Build option
//   REG_FILE_BYPASS_EN  when defined, a read whose address matches an
//                       accepted same-cycle write returns data_in
//                       (write-through). When undefined, the read returns
//                       the previously stored value.
// ============================================================================
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    output logic            busy,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] data_in,
    input  logic            re,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            rs_valid
);

    // One bit wider than an address so NREG == 2**AW still compares correctly.
    localparam logic [AW:0]   NREG_W   = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // An address is live when it maps onto a real entry that is not the
    // hardwired zero register; dead addresses read as zero and drop writes.
    function automatic logic addr_live(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero_reg;
        in_range    = ({1'b0, a} < NREG_W);
        is_zero_reg = (ZERO_REG != 0) && (a == {AW{1'b0}});
        return in_range && !is_zero_reg;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e            state_q,  state_d;
    logic [AW-1:0]     cnt_q,    cnt_d;
    logic              busy_q,   busy_d;
    logic [XLEN-1:0]   rs1_out_q, rs1_out_d;
    logic [XLEN-1:0]   rs2_out_q, rs2_out_d;
    logic              rs_valid_q, rs_valid_d;

    // Storage array; deliberately not reset, the clear sweep zeroes it.
    logic [XLEN-1:0]   mem_q [NREG];

    // Array write port, shared between the clear sweep and normal writes.
    logic              mem_we_s;
    logic [AW-1:0]     mem_waddr_s;
    logic [XLEN-1:0]   mem_wdata_s;

    logic              wr_ok_s;
    logic [XLEN-1:0]   rd1_s;
    logic [XLEN-1:0]   rd2_s;
    logic [XLEN-1:0]   fwd1_s;
    logic [XLEN-1:0]   fwd2_s;

    // Raw array read data with dead addresses forced to zero.
    always_comb begin
        wr_ok_s = we && addr_live(rd);
        if (addr_live(rs1)) begin
            rd1_s = mem_q[rs1];
        end else begin
            rd1_s = {XLEN{1'b0}};
        end
        if (addr_live(rs2)) begin
            rd2_s = mem_q[rs2];
        end else begin
            rd2_s = {XLEN{1'b0}};
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Write-through: an accepted same-cycle write to the read address wins.
    always_comb begin
        if (wr_ok_s && (rd == rs1)) begin
            fwd1_s = data_in;
        end else begin
            fwd1_s = rd1_s;
        end
        if (wr_ok_s && (rd == rs2)) begin
            fwd2_s = data_in;
        end else begin
            fwd2_s = rd2_s;
        end
    end
`else
    // No forwarding: a same-cycle write becomes visible on the next read.
    always_comb begin
        fwd1_s = rd1_s;
        fwd2_s = rd2_s;
    end
`endif

    // Next-state logic for the clear sequencer, write port and read ports.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rs1_out_d   = rs1_out_q;
        rs2_out_d   = rs2_out_q;
        rs_valid_d  = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_q;
        mem_wdata_s = {XLEN{1'b0}};

        case (state_q)
            ST_CLEAR: begin
                // Zero one entry per cycle; we/re are ignored, outputs hold.
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q;
                mem_wdata_s = {XLEN{1'b0}};
                if (init) begin
                    cnt_d = {AW{1'b0}};
                end else if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end

            ST_IDLE: begin
                if (init) begin
                    // A request coinciding with init is dropped entirely.
                    state_d = ST_CLEAR;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    if (wr_ok_s) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = rd;
                        mem_wdata_s = data_in;
                    end else begin
                        mem_we_s    = 1'b0;
                    end
                    if (re) begin
                        rs1_out_d  = fwd1_s;
                        rs2_out_d  = fwd2_s;
                        rs_valid_d = 1'b1;
                    end else begin
                        rs_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {AW{1'b0}};
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    // Control and output registers; reset puts the block into a fresh sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= {AW{1'b0}};
            busy_q     <= 1'b1;
            rs1_out_q  <= {XLEN{1'b0}};
            rs2_out_q  <= {XLEN{1'b0}};
            rs_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rs1_out_q  <= rs1_out_d;
            rs2_out_q  <= rs2_out_d;
            rs_valid_q <= rs_valid_d;
        end
    end

    // Array write; contents survive reset until the sweep reaches them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign busy     = busy_q;
    assign rs1_out  = rs1_out_q;
    assign rs2_out  = rs2_out_q;
    assign rs_valid = rs_valid_q;

endmodule

// File: tb/tb_reg_file_param.sv
// ============================================================================
// tb_reg_file_param
// Two instances (NREG=32 and NREG=20, both AW=5) share one stimulus stream.
// A behavioural model per instance predicts busy/read data; a negedge process
// compares every cycle, and directed steps add hand-computed expectations.
// ============================================================================
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [31:0] data_in = 32'd0;

    logic        a_busy, a_v, b_busy, b_v;
    logic [31:0] a_o1, a_o2, b_o1, b_o2;

    reg_file_param #(.XLEN(32), .NREG(32)) dut_a (
        .clk(clk), .rst(rst), .init(init), .busy(a_busy),
        .we(we), .rd(rd), .data_in(data_in),
        .re(re), .rs1(rs1), .rs2(rs2),
        .rs1_out(a_o1), .rs2_out(a_o2), .rs_valid(a_v)
    );

    reg_file_param #(.XLEN(32), .NREG(20)) dut_b (
        .clk(clk), .rst(rst), .init(init), .busy(b_busy),
        .we(we), .rd(rd), .data_in(data_in),
        .re(re), .rs1(rs1), .rs2(rs2),
        .rs1_out(b_o1), .rs2_out(b_o2), .rs_valid(b_v)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state, index 0 -> dut_a, 1 -> dut_b.
    int          nreg [2] = '{32, 20};
    logic [31:0] mm [2][32];
    int          busy_left [2];
    logic [31:0] e1 [2];
    logic [31:0] e2 [2];
    logic        ev [2];

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic bit live(int k, logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nreg[k]);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = nreg[k];
            e1[k] = 32'd0;
            e2[k] = 32'd0;
            ev[k] = 1'b0;
            for (int j = 0; j < 32; j++) mm[k][j] = 32'd0;
        end
    endtask

    // One rising edge of the model: a clear makes the array all-zero for
    // NREG cycles; otherwise reads see the old contents (or data_in when
    // write-through is built in), then the write lands.
    task automatic model_edge();
        bit          wok;
        logic [31:0] v1;
        logic [31:0] v2;
        for (int k = 0; k < 2; k++) begin
            if (busy_left[k] > 0) begin
                ev[k] = 1'b0;
                if (init) busy_left[k] = nreg[k];
                else      busy_left[k] = busy_left[k] - 1;
            end else if (init) begin
                busy_left[k] = nreg[k];
                ev[k] = 1'b0;
                for (int j = 0; j < 32; j++) mm[k][j] = 32'd0;
            end else begin
                wok = we && live(k, rd);
                v1 = live(k, rs1) ? mm[k][rs1] : 32'd0;
                v2 = live(k, rs2) ? mm[k][rs2] : 32'd0;
                if (BYPASS && wok && rd == rs1) v1 = data_in;
                if (BYPASS && wok && rd == rs2) v2 = data_in;
                if (re) begin
                    e1[k] = v1;
                    e2[k] = v2;
                    ev[k] = 1'b1;
                end else begin
                    ev[k] = 1'b0;
                end
                if (wok) mm[k][rd] = data_in;
            end
        end
    endtask

    task automatic step(bit i_init, bit i_we, logic [4:0] i_rd, logic [31:0] i_d,
                        bit i_re, logic [4:0] i_rs1, logic [4:0] i_rs2);
        init = i_init; we = i_we; rd = i_rd; data_in = i_d;
        re = i_re; rs1 = i_rs1; rs2 = i_rs2;
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic rd_at(logic [4:0] a1, logic [4:0] a2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, a1, a2);
    endtask

    task automatic wr_at(logic [4:0] a, logic [31:0] d);
        step(1'b0, 1'b1, a, d, 1'b0, 5'd0, 5'd0);
    endtask

    // Idle until dut_a drops busy, bounded; returns the edge count.
    task automatic count_busy(output int n);
        n = 0;
        while (a_busy === 1'b1 && n < 100) begin
            idle();
            n++;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("a_busy",  {31'd0, a_busy}, {31'd0, busy_left[0] > 0});
        check("a_valid", {31'd0, a_v},    {31'd0, ev[0]});
        check("a_rs1",   a_o1, e1[0]);
        check("a_rs2",   a_o2, e2[0]);
        check("b_busy",  {31'd0, b_busy}, {31'd0, busy_left[1] > 0});
        check("b_valid", {31'd0, b_v},    {31'd0, ev[1]});
        check("b_rs1",   b_o1, e1[1]);
        check("b_rs2",   b_o2, e2[1]);
    end

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, a_busy}, 32'd1);
        check("rst_out",   a_o1, 32'd0);
        check("rst_valid", {31'd0, a_v}, 32'd0);
        rst = 1'b1;
        count_busy(n);
        check("busy_len_after_rst", n, 32'd32);

        // All addresses read zero after the sweep.
        for (int i = 0; i < 32; i++) rd_at(5'(i), 5'(31 - i));
        check("last_read_valid", {31'd0, a_v}, 32'd1);
        idle();
        check("valid_pulse_end", {31'd0, a_v}, 32'd0);

        // Basic write/read and zero register.
        wr_at(5'd5, 32'hDEADBEEF);
        rd_at(5'd5, 5'd0);
        check("r5_read", a_o1, 32'hDEADBEEF);
        check("r0_read", a_o2, 32'd0);
        wr_at(5'd0, 32'h1234);
        rd_at(5'd0, 5'd0);
        check("r0_after_write", a_o1, 32'd0);

        // Same-cycle write and read of r7.
        wr_at(5'd7, 32'h11);
        step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7);
        check("same_cycle_r7", a_o1, BYPASS ? 32'hA5A5A5A5 : 32'h11);
        rd_at(5'd7, 5'd7);
        check("r7_next_read", a_o1, 32'hA5A5A5A5);

        // Out-of-range and top entry on the NREG=20 instance.
        wr_at(5'd25, 32'hFF);
        rd_at(5'd25, 5'd25);
        check("b_out_of_range", b_o1, 32'd0);
        check("a_r25", a_o1, 32'hFF);
        wr_at(5'd19, 32'h55);
        rd_at(5'd19, 5'd19);
        check("b_r19", b_o2, 32'h55);

        // Fill, then init with a coincident write that must be dropped.
        for (int i = 1; i < 32; i++) wr_at(5'(i), 32'(i));
        rd_at(5'd3, 5'd31);
        check("fill_r31", a_o2, 32'd31);
        step(1'b1, 1'b1, 5'd3, 32'hBAD, 1'b1, 5'd3, 5'd3);
        count_busy(n);
        check("busy_len_init", n, 32'd32);
        for (int i = 0; i < 32; i++) rd_at(5'(i), 5'(i));
        rd_at(5'd3, 5'd30);
        check("r3_after_init", a_o1, 32'd0);

        // Re-init ten cycles into a clear extends busy from the second pulse.
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        repeat (10) idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        count_busy(n);
        check("busy_len_reinit", n, 32'd32);

        // Reset in the middle of a clear (counter at 12).
        wr_at(5'd9, 32'h77);
        rd_at(5'd9, 5'd9);
        check("r9_read", a_o1, 32'h77);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        repeat (12) idle();
        check("hold_during_clear", a_o1, 32'h77);
        rst = 1'b0;
        model_reset();
        #1;
        check("midclear_rst_busy", {31'd0, a_busy}, 32'd1);
        check("midclear_rst_out",  a_o1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        count_busy(n);
        check("busy_len_rst2", n, 32'd32);

        // Randomized traffic, including occasional init and rs1 == rs2.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a1;
            a1 = 5'($urandom);
            step(($urandom_range(0, 99) == 0), 1'($urandom), 5'($urandom), $urandom,
                 1'($urandom), a1, ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom));
        end

        // Random reset while reads are in flight.
        rd_at(5'd1, 5'd2);
        rst = 1'b0;
        model_reset();
        #1;
        check("midread_rst_valid", {31'd0, a_v}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        count_busy(n);
        check("busy_len_rst3", n, 32'd32);
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 5'($urandom), 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised general-purpose register file for the RISC-V datapath, succeeding the fixed 32x32 read-or-write register file. It provides two independent registered read ports and one write port usable in the same cycle, a hardwired-zero register 0, and a hardware clear sequencer that zeroes the array one entry per cycle after reset or on request. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers (2..256; need not be a power of two)
- AW, $clog2(NREG), address width (derived; not overridden)
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- init  input  1  synchronous clear request (single-cycle pulse)
- busy  output  1  clear sequence in progress; array ops ignored
- we  input  1  write enable
- rd  input  AW  write address
- data_in  input  XLEN  write data
- re  input  1  read enable (both ports)
- rs1  input  AW  read address, port 1
- rs2  input  AW  read address, port 2
- rs1_out  output  XLEN  registered read data, port 1
- rs2_out  output  XLEN  registered read data, port 2
- rs_valid  output  1  read data valid, one-cycle pulse

## Operation
- FSM states: CLEAR, IDLE. busy = (state == CLEAR), registered.
- rst low (async): state <= CLEAR, clear counter <= 0, rs1_out/rs2_out <= 0, rs_valid <= 0, busy <= 1. Array contents not reset asynchronously.
- CLEAR: each cycle writes 0 to entry[counter], counter++; after entry NREG-1 is written, state <= IDLE. we/re ignored (no write, rs_valid stays 0, outputs hold).
- init high in IDLE: state <= CLEAR, counter <= 0; a simultaneous we/re is dropped. init high in CLEAR: counter restarts at 0.
- IDLE, we=1: entry[rd] <= data_in at clock edge, unless (ZERO_REG && rd==0) or rd >= NREG (dropped).
- IDLE, re=1: rs1_out <= entry[rs1], rs2_out <= entry[rs2], rs_valid <= 1 next cycle. re=0: outputs hold, rs_valid <= 0.
- Read of address 0 with ZERO_REG=1, or of address >= NREG: returns 0.
- Same-cycle we and re, matching address: behaviour per BYPASS_EN (Configuration). Distinct addresses: independent.
- rs1 == rs2 legal; both ports return same value.

## Timing
- Read latency 1 cycle: addresses sampled at edge N, data and rs_valid visible after edge N, valid for exactly one cycle unless re held.
- Write visible to reads sampled at the following edge (N+1) without bypass.
- After rst release: busy=1 for exactly NREG rising edges; first edge clears entry 0; busy low after the NREG-th edge; first accepted op at edge NREG+1.
- init pulse at edge N: busy high after edge N, low after edge N+NREG.
- rst asserted mid-CLEAR or mid-read: immediate return to reset values; sequence restarts from entry 0 on release.

## Configuration
- REG_FILE_BYPASS_EN defined: same-cycle we and re with rd == rs1 (or rs2), write legal, returns data_in on that port (write-through). Write to zero register / out-of-range address not forwarded (still 0).
- Not defined: such a read returns the old stored value; new value seen from next read.

## Test plan
- Reset release, NREG=32 -> busy=1 for 32 cycles, then 0; reads of all 32 addresses return 0, rs_valid pulses each read.
- Write 0xDEADBEEF to r5, next cycle read rs1=5, rs2=0 -> rs1_out=0xDEADBEEF, rs2_out=0; write 0x1234 to r0 then read r0 -> 0.
- Same cycle we rd=7 data 0xA5A5A5A5 and re rs1=7 (r7 previously 0x11) -> rs1_out=0xA5A5A5A5 with REG_FILE_BYPASS_EN, 0x11 without.
- NREG=20: write 0xFF to address 25, read 25 -> 0; write/read 19 -> value returned.
- Fill r1..r31 with index values, pulse init with we=1 rd=3 -> write dropped, busy 32 cycles, all reads 0 afterward; init again at cycle 10 of clear -> busy extends to 32 cycles from second pulse.
- Assert rst mid-clear (counter=12) -> outputs 0, busy=1 immediately; after release full 32-cycle sweep repeats.
